// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous pushbutton into a clean level via a synchroniser and a
// counter-qualified 4-state FSM. Optional rejected-glitch counter: DEBOUNCE_GLITCH_CNT_EN.
module button_debouncer #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 50000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   output logic       btn_level,
   output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam logic [1:0] StIdleLo = 2'd0;
   localparam logic [1:0] StQualHi = 2'd1;
   localparam logic [1:0] StIdleHi = 2'd2;
   localparam logic [1:0] StQualLo = 2'd3;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   abort;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort   = 1'b0;
      case (state_q)
         StIdleLo: begin
            if (s) begin
               state_d = StQualHi;
               cnt_d   = '0;
            end
         end
         StQualHi: begin
            if (!s) begin
               state_d = StIdleLo;
               abort   = 1'b1;
            end else if (cnt_q == CntLast) begin
               state_d = StIdleHi;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StIdleHi: begin
            if (!s) begin
               state_d = StQualLo;
               cnt_d   = '0;
            end
         end
         default: begin
            if (s) begin
               state_d = StIdleHi;
               abort   = 1'b1;
            end else if (cnt_q == CntLast) begin
               state_d = StIdleLo;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdleLo;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Moore decode from the state register only; nothing combinational from btn_raw.
   assign btn_level = (state_q == StIdleHi) || (state_q == StQualLo);
   assign busy      = (state_q == StQualHi) || (state_q == StQualLo);

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         glitch_q <= '0;
      end else if (abort && (glitch_q != 8'hff)) begin
         glitch_q <= glitch_q + 8'd1;
      end
   end

   assign glitch_cnt = glitch_q;
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized bouncing input,
// compared every cycle against a run-length model of the debounce rule.
module tb_button_debouncer;

   localparam int unsigned SYNC   = 2;
   localparam int unsigned STABLE = 4;
   localparam int unsigned CW     = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b1;
   logic btn_level;
   logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   int checks = 0;
   int errors = 0;

   button_debouncer #(
      .SYNC_STAGES  (SYNC),
      .STABLE_CYCLES(STABLE),
      .CNT_W        (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .busy     (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: the FSM sees btn_raw delayed by SYNC edges. A change is accepted once the seen value
   // has differed from the level for STABLE+1 consecutive edges; any shorter run is a glitch.
   bit          m_level;
   int unsigned m_run;
   int unsigned m_glitch;
   bit          m_q[$];

   task automatic model_reset();
      m_q = {};
      for (int i = 0; i < int'(SYNC); i++) m_q.push_back(1'b0);
      m_level  = 1'b0;
      m_run    = 0;
      m_glitch = 0;
   endtask

   initial begin
      bit s;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            s = m_q.pop_front();
            m_q.push_back(btn_raw);
            if (s != m_level) begin
               m_run++;
               if (m_run == STABLE + 1) begin
                  m_level = s;
                  m_run   = 0;
               end
            end else begin
               if (m_run > 0 && m_glitch < 255) m_glitch++;
               m_run = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("cyc_level", 32'(btn_level), 32'(m_level));
         chk("cyc_busy", 32'(busy), 32'(m_run > 0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
         chk("cyc_glitch", 32'(glitch_cnt), m_glitch);
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      // 1: reset while held, then requalify from scratch
      tick(3);
      chk("rst_level", 32'(btn_level), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("rst_glitch", 32'(glitch_cnt), 0);
`endif
      rst = 1'b0;
      tick(6);
      chk("t1_e6_level", 32'(btn_level), 0);
      chk("t1_e6_busy", 32'(busy), 1);
      tick(1);
      chk("t1_e7_level", 32'(btn_level), 1);
      chk("t1_e7_model", 32'(m_level), 1);

      // 2: clean press
      btn_raw = 1'b0;
      tick(10);
      chk("t2_low", 32'(btn_level), 0);
      btn_raw = 1'b1;
      tick(2);
      chk("t2_e2_busy", 32'(busy), 0);
      tick(1);
      chk("t2_e3_busy", 32'(busy), 1);
      tick(3);
      chk("t2_e6_level", 32'(btn_level), 0);
      tick(1);
      chk("t2_e7_level", 32'(btn_level), 1);
      chk("t2_e7_busy", 32'(busy), 0);

      // 3: bounce 1,1,0 then held high
      btn_raw = 1'b0;
      tick(10);
      btn_raw = 1'b1;
      tick(2);
      btn_raw = 1'b0;
      tick(1);
      btn_raw = 1'b1;
      tick(6);
      chk("t3_e9_level", 32'(btn_level), 0);
      tick(1);
      chk("t3_e10_level", 32'(btn_level), 1);
      chk("t3_model_glitch", m_glitch, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("t3_glitch", 32'(glitch_cnt), 1);
`endif

      // 4: 3-clock low glitch while high, then clean release
      btn_raw = 1'b0;
      tick(3);
      btn_raw = 1'b1;
      tick(10);
      chk("t4_hold_level", 32'(btn_level), 1);
      chk("t4_model_glitch", m_glitch, 2);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("t4_glitch", 32'(glitch_cnt), 2);
`endif
      btn_raw = 1'b0;
      tick(6);
      chk("t4_e6_level", 32'(btn_level), 1);
      tick(1);
      chk("t4_e7_level", 32'(btn_level), 0);

      // 5: 260 single-clock pulses saturate the glitch count
      for (int i = 0; i < 260; i++) begin
         btn_raw = 1'b1;
         tick(1);
         btn_raw = 1'b0;
         tick(7);
      end
      chk("t5_level", 32'(btn_level), 0);
      chk("t5_model_glitch", m_glitch, 255);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("t5_glitch", 32'(glitch_cnt), 255);
`endif

      // 6: reset in QUAL_HI with cnt=2
      btn_raw = 1'b1;
      tick(5);
      chk("t6_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_level", 32'(btn_level), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      tick(2);
      rst = 1'b0;
      tick(6);
      chk("t6_e6_level", 32'(btn_level), 0);
      tick(1);
      chk("t6_e7_level", 32'(btn_level), 1);

      // Randomized bouncing runs with occasional asynchronous resets
      for (int i = 0; i < 600; i++) begin
         btn_raw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(STABLE, STABLE + 8)));
         else tick(int'($urandom_range(1, STABLE + 1)));
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            tick(int'($urandom_range(1, 3)));
            rst = 1'b0;
         end
      end
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
